brm_density_decoder: RTL and testbench
======================================

# brm_density_decoder

Receive-side companion to the binary rate multiplier. Takes the serial pulse stream `Z` and the sample-enable `X` that the multiplier drives. Over each window of 2^WIDTH enabled samples it counts the `Z` pulses, which recovers the rate word as a pulse count. Each result goes out through a valid/ready holding register. The block sits at the far end of the rate-multiplier link, aligned to the transmitter's counter by `Sync`.

## Interface
- `WIDTH`, default 16: rate-counter width. The window is 2^WIDTH enabled samples.
- `CK` input 1: clock; all state changes on the rising edge.
- `Reset_N` input 1: asynchronous, active-low reset.
- `Clear` input 1: synchronous clear. Has the same effect as reset, applied at the edge.
- `X` input 1: sample enable; only cycles with `X`=1 count as samples.
- `Z_in` input 1: pulse stream from the multiplier; sampled only when `X`=1.
- `Sync` input 1: window alignment; the multiplier's counter is at zero on this sample.
- `Ready` input 1: consumer accepts `Count` when `Valid`=1.
- `Count` output WIDTH+1: recovered pulse count, range 0..2^WIDTH.
- `Valid` output 1: `Count` holds an unconsumed result.
- `W` output 1: window-terminal indicator. High combinationally while `X`=1, state is RUN and the window counter is all-ones.
- `Overrun` output 1: sticky; a result was overwritten before it was accepted.
- `Locked` output 1: state is RUN.

## Operation
- Reset or `Clear`: the following values apply.
  - State is IDLE.
  - Window counter, accumulator and `Count` are 0.
  - `Valid`, `Overrun` and `Locked` are 0.
- States:
  - IDLE: samples are ignored. `Sync`&`X` moves to RUN, with that sample taken as index 0.
  - RUN: each `X`=1 cycle increments the WIDTH-bit window counter and adds `Z_in` to the (WIDTH+1)-bit accumulator.
- Window end: occurs in RUN on an `X`=1 cycle where the window counter is all-ones.
  - `Count` <= accumulator + `Z_in`.
  - `Valid` <= 1.
  - Accumulator <= 0 and window counter wraps to 0.
- `Sync`&`X` while in RUN: window counter <= 1 and accumulator <= `Z_in`, so that sample is index 0. No result is emitted for the dropped partial window. If this coincides with a window end, the window end wins and counts as a normal completion.
- Handshake:
  - `Valid`&`Ready` at an edge clears `Valid`, unless a new result loads on the same edge.
  - If a new result loads on the same edge, `Valid` stays 1 and `Overrun` is not set.
  - If a new result loads while `Valid`=1 and `Ready`=0, `Count` is overwritten and `Overrun` <= 1.
- `Overrun` clears only on reset or `Clear`.
- Arithmetic: the accumulator cannot overflow, because 2^WIDTH samples gives at most 2^WIDTH pulses. No saturation logic is required.
- `X`=0 cycles freeze the window counter and accumulator; gaps have no effect on the result.

## Timing
- `Count` and `Valid` update on the edge that samples the final window sample. They are visible in the following cycle, so latency is 1 cycle.
- `W` is combinational from `X` and state; it has no register delay.
- Minimum result spacing is 2^WIDTH cycles (`X` held at 1). `Ready` may be held high continuously.
- `Reset_N` is asynchronous on assertion. Deassertion is synchronised externally; the block needs no internal synchroniser.
- If reset lands mid-window, the partial window is discarded and the block returns to IDLE. The next `Sync` is required before counting resumes.

## Structure
- Shared package: `brm_pkg` holds the following.
  - `BRM_WIDTH_DEFAULT` = 16.
  - State enum `brm_rx_state_t` {IDLE, RUN}.
  - Helper function `brm_window_last(cnt)` for the all-ones test. The transmitter-side wrapper shares this function.
- One sub-module: `brm_result_reg`. It is the valid/ready holding register with overrun detection, and is parameterised on data width. Window counter, accumulator and FSM stay in the top module.

## Test plan
All scenarios use WIDTH=4, so one window is 16 samples.
- Reset, then `Sync` with `X`=1 and `Z_in`=1 for 16 samples, `Ready`=1 -> one cycle after sample 15, `Count`=16 and `Valid`=1 for one cycle. `W` is high during sample 15.
- Z pattern 1,0,0,1,0,1,0,0,0,1,0,0,1,0,0,0 with random `X` gaps -> `Count`=5. Gaps do not change the result.
- `Ready`=0 across two full windows with counts 3 then 7 -> `Count`=7, `Valid`=1, `Overrun`=1. After `Ready`, `Valid`=0 and `Overrun` stays 1 until `Clear`.
- `Sync` reasserted at sample 9 of a window -> no result for the partial window. The next result arrives 16 samples after the resync, counting only pulses from the resync sample onward.
- `Reset_N` pulsed low at sample 6 -> all outputs are 0 immediately, without waiting for a clock edge, and `Locked`=0. Samples are ignored until the next `Sync`.
- `Ready`=1 on the same edge that a new result loads, with `Valid`=1 -> `Valid` stays 1, `Count` takes the new value, and `Overrun` stays 0.

Source files
------------

// File: rtl/brm_pkg.sv
// Shared types and helpers for the binary rate multiplier link.
// Used by both the transmitter wrapper and the density decoder.
package brm_pkg;

    localparam int BRM_WIDTH_DEFAULT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } brm_rx_state_t;

    // True when the low 'width' bits of cnt are all ones.
    // The caller zero-extends its counter to 32 bits.
    function automatic logic brm_window_last(
        input logic [31:0] cnt,
        input int unsigned width
    );
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF
                             : ((32'd1 << width) - 32'd1);
        return (cnt & mask) == mask;
    endfunction

endpackage

// File: rtl/brm_result_reg.sv
// Valid/ready holding register with sticky overrun detection.
// Ports: i_clk, i_rst_n (async low), i_clear (sync), i_load/i_data
//        (new result), i_ready (consumer), o_data/o_valid/o_overrun.
module brm_result_reg #(
    parameter int DW = 17
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    output logic          o_overrun
);

    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          r_overrun;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (i_clear) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (i_load) begin
            // A result still pending and not taken this edge is lost.
            r_data  <= i_data;
            r_valid <= 1'b1;
            if (r_valid && !i_ready)
                r_overrun <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/brm_density_decoder.sv
// Recovers the rate word from a BRM pulse stream by counting Z pulses
// over windows of 2^WIDTH enabled samples aligned by Sync.
// Ports: CK, Reset_N (async low), Clear (sync), X (sample enable),
//        Z_in (pulses), Sync (window align), Ready (consumer),
//        Count/Valid (result), W (terminal sample), Overrun, Locked.
module brm_density_decoder
    import brm_pkg::*;
#(
    parameter int WIDTH = BRM_WIDTH_DEFAULT
) (
    input  logic             CK,
    input  logic             Reset_N,
    input  logic             Clear,
    input  logic             X,
    input  logic             Z_in,
    input  logic             Sync,
    input  logic             Ready,
    output logic [WIDTH:0]   Count,
    output logic             Valid,
    output logic             W,
    output logic             Overrun,
    output logic             Locked
);

    brm_rx_state_t    r_state;
    brm_rx_state_t    w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH:0]   w_acc_nxt;
    logic [WIDTH:0]   w_z_ext;
    logic [WIDTH:0]   w_sum;
    logic             w_last;
    logic             w_load;

    assign w_z_ext = {{WIDTH{1'b0}}, Z_in};
    assign w_sum   = r_acc + w_z_ext;
    assign w_last  = brm_window_last(32'(r_cnt), WIDTH);

    always_ff @(posedge CK or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (Clear) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_load      = 1'b0;
        unique case (r_state)
            IDLE: begin
                // The Sync sample itself is index 0 of the window.
                if (X && Sync) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = WIDTH'(1);
                    w_acc_nxt   = w_z_ext;
                end
            end
            RUN: begin
                if (X) begin
                    // Window end takes priority over a coincident Sync.
                    if (w_last) begin
                        w_load    = 1'b1;
                        w_cnt_nxt = '0;
                        w_acc_nxt = '0;
                    end else if (Sync) begin
                        w_cnt_nxt = WIDTH'(1);
                        w_acc_nxt = w_z_ext;
                    end else begin
                        w_cnt_nxt = r_cnt + WIDTH'(1);
                        w_acc_nxt = w_sum;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign W      = X && (r_state == RUN) && w_last;
    assign Locked = (r_state == RUN);

    brm_result_reg #(
        .DW(WIDTH + 1)
    ) u_result (
        .i_clk     (CK),
        .i_rst_n   (Reset_N),
        .i_clear   (Clear),
        .i_load    (w_load),
        .i_data    (w_sum),
        .i_ready   (Ready),
        .o_data    (Count),
        .o_valid   (Valid),
        .o_overrun (Overrun)
    );

endmodule

// File: tb/tb_brm_density_decoder.sv
// Bench for brm_density_decoder at WIDTH=4 (16-sample windows).
// Reference model keeps the current window's samples in a queue.
module tb_brm_density_decoder;

    localparam int WD  = 4;
    localparam int WIN = 1 << WD;

    logic          CK = 1'b0;
    logic          Reset_N = 1'b0;
    logic          Clear = 1'b0;
    logic          X = 1'b0;
    logic          Z_in = 1'b0;
    logic          Sync = 1'b0;
    logic          Ready = 1'b0;
    logic [WD:0]   Count;
    logic          Valid;
    logic          W;
    logic          Overrun;
    logic          Locked;

    brm_density_decoder #(.WIDTH(WD)) dut (
        .CK      (CK),
        .Reset_N (Reset_N),
        .Clear   (Clear),
        .X       (X),
        .Z_in    (Z_in),
        .Sync    (Sync),
        .Ready   (Ready),
        .Count   (Count),
        .Valid   (Valid),
        .W       (W),
        .Overrun (Overrun),
        .Locked  (Locked)
    );

    always #5 CK = ~CK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_run;
    bit mq[$];
    int m_count;
    bit m_valid;
    bit m_ovr;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run   = 0;
        mq.delete();
        m_count = 0;
        m_valid = 0;
        m_ovr   = 0;
    endtask

    function automatic int qsum();
        int s = 0;
        foreach (mq[i]) s += int'(mq[i]);
        return s;
    endfunction

    task automatic model_edge(input bit x, input bit z, input bit s,
                              input bit r, input bit c);
        bit loaded;
        int res;
        loaded = 0;
        res    = 0;
        if (c) begin
            model_reset();
            return;
        end
        if (x) begin
            if (!m_run) begin
                if (s) begin
                    m_run = 1;
                    mq.delete();
                    mq.push_back(z);
                end
            end else if (mq.size() == WIN - 1) begin
                res    = qsum() + int'(z);
                loaded = 1;
                mq.delete();
            end else if (s) begin
                mq.delete();
                mq.push_back(z);
            end else begin
                mq.push_back(z);
            end
        end
        if (loaded) begin
            if (m_valid && !r) m_ovr = 1;
            m_count = res;
            m_valid = 1;
        end else if (m_valid && r) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outs();
        chk("Count",   int'(Count),   m_count);
        chk("Valid",   int'(Valid),   int'(m_valid));
        chk("Overrun", int'(Overrun), int'(m_ovr));
        chk("Locked",  int'(Locked),  int'(m_run));
    endtask

    task automatic cyc(input bit x, input bit z, input bit s,
                       input bit r, input bit c);
        @(negedge CK);
        X = x; Z_in = z; Sync = s; Ready = r; Clear = c;
        #1;
        chk("W", int'(W), int'(x && m_run && mq.size() == WIN - 1));
        @(posedge CK);
        model_edge(x, z, s, r, c);
        #1;
        check_outs();
    endtask

    int zpat[16] = '{1,0,0,1,0,1,0,0,0,1,0,0,1,0,0,0};

    initial begin
        model_reset();
        #12;
        check_outs();
        @(negedge CK);
        Reset_N = 1'b1;

        // Full-density window
        for (int i = 0; i < WIN; i++)
            cyc(1, 1, i == 0, 1, 0);
        chk("t1_count", int'(Count), 16);
        chk("t1_valid", int'(Valid), 1);
        cyc(0, 0, 0, 1, 0);
        chk("t1_valid_drop", int'(Valid), 0);

        // Pattern with random X gaps
        for (int i = 0; i < WIN; i++) begin
            int g = int'($urandom_range(0, 2));
            for (int k = 0; k < g; k++)
                cyc(0, 1'($urandom), 0, 1, 0);
            cyc(1, 1'(zpat[i]), 0, 1, 0);
        end
        chk("t2_count", int'(Count), 5);

        // Two windows with Ready low: overrun
        for (int i = 0; i < WIN; i++) cyc(1, i < 3, 0, 0, 0);
        for (int i = 0; i < WIN; i++) cyc(1, i < 7, 0, 0, 0);
        chk("t3_count", int'(Count), 7);
        chk("t3_ovr",   int'(Overrun), 1);
        cyc(0, 0, 0, 1, 0);
        chk("t3_valid", int'(Valid), 0);
        chk("t3_ovr_sticky", int'(Overrun), 1);
        cyc(0, 0, 0, 1, 1);
        chk("t3_ovr_clr", int'(Overrun), 0);
        chk("t3_unlock", int'(Locked), 0);

        // Resync at sample 9
        for (int i = 0; i < 9; i++) cyc(1, 1, i == 0, 1, 0);
        for (int j = 0; j < WIN; j++) begin
            cyc(1, 1'(j & 1), j == 0, 1, 0);
            if (j == WIN - 2) chk("t4_nores", int'(Valid), 0);
        end
        chk("t4_count", int'(Count), 8);

        // Async reset at sample 6 (Valid still pending from above)
        for (int i = 0; i < 6; i++) cyc(1, 1, i == 0, 0, 0);
        @(negedge CK);
        X = 1; Z_in = 1; Sync = 0; Ready = 0; Clear = 0;
        #1 Reset_N = 1'b0;
        #1;
        chk("t5_count",  int'(Count), 0);
        chk("t5_valid",  int'(Valid), 0);
        chk("t5_locked", int'(Locked), 0);
        chk("t5_w",      int'(W), 0);
        model_reset();
        @(posedge CK);
        #1 check_outs();
        @(negedge CK);
        Reset_N = 1'b1;
        for (int i = 0; i < 20; i++) cyc(1, 1, 0, 1, 0);
        chk("t5_idle", int'(Locked), 0);

        // Ready on the same edge as a new load
        for (int i = 0; i < WIN; i++) cyc(1, i < 4, i == 0, 0, 0);
        for (int i = 0; i < WIN; i++)
            cyc(1, i < 9, 0, i == WIN - 1, 0);
        chk("t6_count", int'(Count), 9);
        chk("t6_valid", int'(Valid), 1);
        chk("t6_ovr",   int'(Overrun), 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bit x, z, s, r, c;
            x = ($urandom % 4) != 0;
            z = 1'($urandom);
            s = ($urandom % 50) == 0;
            r = ($urandom % 10) < 7;
            c = ($urandom % 400) == 0;
            cyc(x, z, s, r, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
